// File: rtl/rr_grant_sequencer.sv
// Grant-issuing back end of the round-robin arbiter: turns the pre-calculator's candidate
// mask into one held, one-hot grant and feeds the owner back as last_grant.
module rr_grant_sequencer #(
    parameter int CHANNELS = 8,
    parameter int MAX_HOLD = 16,
    parameter int IDX_W    = $clog2(CHANNELS),
    parameter int CNT_W    = $clog2(MAX_HOLD)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] request,
    input  logic [CHANNELS-1:0] next_grant,
    input  logic [CHANNELS-1:0] done,
    output logic [CHANNELS-1:0] grant,
    output logic                grant_valid,
    output logic [IDX_W-1:0]    grant_idx,
    output logic [CHANNELS-1:0] last_grant,
    output logic                timeout
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        SETTLE = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [CHANNELS-1:0] grant_nxt, last_nxt;
    logic                valid_nxt, timeout_nxt;
    logic [IDX_W-1:0]    idx_nxt;

    logic [CHANNELS-1:0] cand;
    logic [IDX_W-1:0]    pick_idx;
    logic                owner_done, owner_req, at_limit;

    // A stale mask from the pre-calculator may name channels that already dropped.
    assign cand       = next_grant & request;
    assign owner_done = done[grant_idx];
    assign owner_req  = request[grant_idx];
    assign at_limit   = (cnt == CNT_W'(MAX_HOLD - 1));

    always_comb begin
        pick_idx = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (cand[i]) pick_idx = IDX_W'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_idx   <= '0;
            last_grant  <= '0;
            timeout     <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            grant       <= grant_nxt;
            grant_valid <= valid_nxt;
            grant_idx   <= idx_nxt;
            last_grant  <= last_nxt;
            timeout     <= timeout_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        grant_nxt   = grant;
        valid_nxt   = grant_valid;
        idx_nxt     = grant_idx;
        last_nxt    = last_grant;
        timeout_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (|cand) begin
                    grant_nxt = CHANNELS'(1) << pick_idx;
                    last_nxt  = CHANNELS'(1) << pick_idx;
                    idx_nxt   = pick_idx;
                    valid_nxt = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (owner_done || !owner_req || at_limit) begin
                    grant_nxt   = '0;
                    valid_nxt   = 1'b0;
                    // A coincident done or request drop is a normal release, not a timeout.
                    timeout_nxt = owner_req && !owner_done;
                    state_nxt   = SETTLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            SETTLE: begin
                // Lets the pre-calculator register the updated last_grant before resampling.
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_rr_grant_sequencer.sv
// Directed bench for rr_grant_sequencer with a small round-robin pre-calculator model
// that can be switched in to close the rotation loop.
module tb_rr_grant_sequencer;

    localparam int CHANNELS = 8;
    localparam int MAX_HOLD = 4;
    localparam int IDX_W    = $clog2(CHANNELS);

    logic                clk;
    logic                reset;
    logic [CHANNELS-1:0] request;
    logic [CHANNELS-1:0] next_grant;
    logic [CHANNELS-1:0] done;
    logic [CHANNELS-1:0] grant;
    logic                grant_valid;
    logic [IDX_W-1:0]    grant_idx;
    logic [CHANNELS-1:0] last_grant;
    logic                timeout;

    logic [CHANNELS-1:0] ng_drive;
    logic [CHANNELS-1:0] pc_mask;
    logic                loop_mode;

    logic [CHANNELS-1:0] exp_q[$];
    int                  checks;
    int                  errors;

    rr_grant_sequencer #(
        .CHANNELS (CHANNELS),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .request     (request),
        .next_grant  (next_grant),
        .done        (done),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .last_grant  (last_grant),
        .timeout     (timeout)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // round-robin pre-calculator model: first requester after the last owner
    function automatic logic [CHANNELS-1:0] rr_next(input logic [CHANNELS-1:0] req,
                                                     input logic [CHANNELS-1:0] last);
        int start = 0;
        logic [CHANNELS-1:0] r = '0;
        for (int i = 0; i < CHANNELS; i++) if (last[i]) start = (i + 1) % CHANNELS;
        for (int k = CHANNELS - 1; k >= 0; k--)
            if (req[(start + k) % CHANNELS]) r = CHANNELS'(1) << ((start + k) % CHANNELS);
        return r;
    endfunction

    always @(posedge clk) begin
        if (reset) pc_mask <= '0;
        else       pc_mask <= rr_next(request, last_grant);
    end

    assign next_grant = loop_mode ? pc_mask : ng_drive;

    // scoreboard
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_grant(input logic [CHANNELS-1:0] e);
        exp_q.push_back(e);
    endtask

    task automatic chk_grant(input string tag);
        logic [CHANNELS-1:0] e;
        e = exp_q.pop_front();
        chk(tag, 32'(grant), 32'(e));
        chk({tag, "_valid"}, 32'(grant_valid), 32'(|e));
    endtask

    task automatic wait_grant(input int budget, output int n);
        n = 0;
        while (grant == '0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("wait_grant_seen", 32'(grant != '0), 32'd1);
    endtask

    // directed stimulus
    initial begin
        int lat;
        logic [CHANNELS-1:0] one;
        one       = 8'h01;
        checks    = 0;
        errors    = 0;
        loop_mode = 1'b0;
        reset     = 1'b1;
        request   = 8'hFF;
        ng_drive  = 8'hFF;
        done      = '0;

        // reset held three cycles with full traffic
        repeat (3) begin
            @(negedge clk);
            chk("rst_grant", 32'(grant), 32'h0);
            chk("rst_valid", 32'(grant_valid), 32'h0);
            chk("rst_idx", 32'(grant_idx), 32'h0);
            chk("rst_last", 32'(last_grant), 32'h0);
            chk("rst_timeout", 32'(timeout), 32'h0);
        end
        reset = 1'b0;
        push_grant(8'h01);
        @(negedge clk);
        chk_grant("first_grant");
        chk("first_last", 32'(last_grant), 32'h01);
        request  = '0;
        ng_drive = '0;
        @(negedge clk);
        chk("first_rel", 32'(grant), 32'h0);
        @(negedge clk);

        // single owner, done on third grant cycle
        request  = 8'h04;
        ng_drive = 8'h04;
        repeat (3) push_grant(8'h04);
        @(negedge clk);
        chk_grant("single_c1");
        chk("single_idx", 32'(grant_idx), 32'd2);
        chk("single_last", 32'(last_grant), 32'h04);
        @(negedge clk);
        chk_grant("single_c2");
        @(negedge clk);
        chk_grant("single_c3");
        done = 8'h04;
        @(negedge clk);
        done = '0;
        chk("single_rel", 32'(grant), 32'h0);
        chk("single_rel_last", 32'(last_grant), 32'h04);
        chk("single_rel_to", 32'(timeout), 32'h0);
        @(negedge clk);

        // multi-hot candidate then stale mask
        ng_drive = 8'h30;
        request  = 8'h31;
        push_grant(8'h10);
        @(negedge clk);
        chk_grant("multi_grant");
        chk("multi_idx", 32'(grant_idx), 32'd4);
        ng_drive = 8'h02;
        request  = 8'h01;
        @(negedge clk);
        chk("multi_rel", 32'(grant), 32'h0);
        repeat (2) begin
            @(negedge clk);
            chk("stale_idle", 32'(grant), 32'h0);
        end
        chk("stale_last", 32'(last_grant), 32'h10);
        chk("stale_idx", 32'(grant_idx), 32'd4);

        // hold limit without done
        request  = 8'h80;
        ng_drive = 8'h80;
        repeat (MAX_HOLD) push_grant(8'h80);
        for (int i = 0; i < MAX_HOLD; i++) begin
            @(negedge clk);
            chk_grant("hold_grant");
            chk("hold_to_low", 32'(timeout), 32'h0);
        end
        chk("hold_idx", 32'(grant_idx), 32'd7);
        @(negedge clk);
        chk("hold_rel", 32'(grant), 32'h0);
        chk("hold_timeout", 32'(timeout), 32'h1);
        @(negedge clk);
        chk("hold_to_clear", 32'(timeout), 32'h0);
        chk("hold_idle", 32'(grant), 32'h0);

        // done coincident with the hold limit
        repeat (MAX_HOLD) push_grant(8'h80);
        for (int i = 0; i < MAX_HOLD; i++) begin
            @(negedge clk);
            chk_grant("coinc_grant");
            if (i == MAX_HOLD - 1) done = 8'h80;
        end
        @(negedge clk);
        chk("coinc_rel", 32'(grant), 32'h0);
        chk("coinc_timeout", 32'(timeout), 32'h0);
        done    = '0;
        request = '0;
        @(negedge clk);

        // foreign done ignored, request drop releases
        request  = 8'h08;
        ng_drive = 8'h08;
        repeat (2) push_grant(8'h08);
        @(negedge clk);
        chk_grant("drop_c1");
        done = (8'($urandom_range(1, 255)) | 8'h20) & ~8'h08;
        @(negedge clk);
        chk_grant("foreign_done");
        done    = '0;
        request = '0;
        @(negedge clk);
        chk("drop_rel", 32'(grant), 32'h0);
        chk("drop_to", 32'(timeout), 32'h0);
        chk("drop_last", 32'(last_grant), 32'h08);
        @(negedge clk);

        // closed loop with the pre-calculator, full traffic
        loop_mode = 1'b1;
        request   = 8'hFF;
        reset     = 1'b1;
        @(negedge clk);
        chk("loop_rst", 32'(grant), 32'h0);
        reset = 1'b0;
        push_grant(8'h01);
        wait_grant(6, lat);
        chk("loop_lat", 32'(lat), 32'd2);
        chk_grant("loop_g0");
        for (int k = 1; k <= 9; k++) begin
            done = grant;
            @(negedge clk);
            done = '0;
            chk("loop_dead1", 32'(grant), 32'h0);
            @(negedge clk);
            chk("loop_dead2", 32'(grant), 32'h0);
            push_grant(one << (k % CHANNELS));
            @(negedge clk);
            chk_grant("loop_grant");
        end

        // reset mid-grant restarts rotation at channel 0
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_grant", 32'(grant), 32'h0);
        chk("midrst_valid", 32'(grant_valid), 32'h0);
        chk("midrst_last", 32'(last_grant), 32'h0);
        chk("midrst_idx", 32'(grant_idx), 32'h0);
        reset = 1'b0;
        push_grant(8'h01);
        wait_grant(6, lat);
        chk("midrst_lat", 32'(lat), 32'd2);
        chk_grant("midrst_restart");

        // final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
